// File: rtl/core_mem_pkg.sv
// Shared types for the core memory arbiter slice.
// Bus widths, requester select encoding and request payload bundle.
package core_mem_pkg;

    localparam int CORE_MEM_ADDR_W = 64;
    localparam int CORE_MEM_DATA_W = 64;

    typedef enum logic {
        ARB_IMEM = 1'b0,
        ARB_DMEM = 1'b1
    } arb_sel_t;

    typedef struct packed {
        logic [CORE_MEM_ADDR_W-1:0]   addr;
        logic                         wen;
        logic [CORE_MEM_DATA_W/8-1:0] strb;
        logic [CORE_MEM_DATA_W-1:0]   wdata;
    } mem_bus_t;

endpackage

// File: rtl/core_mem_arbiter.sv
// Fetch / load-store arbiter onto the single core memory port.
// Define CORE_MEM_ARB_FAIRNESS_EN to bound fetch starvation.
module core_mem_arbiter
    import core_mem_pkg::*;
#(
    parameter int ADDR_W       = CORE_MEM_ADDR_W,
    parameter int DATA_W       = CORE_MEM_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                g_clk,
    input  logic                g_resetn,

    input  logic                imem_req,
    input  logic                imem_wen,
    input  logic [ADDR_W-1:0]   imem_addr,
    input  logic [DATA_W/8-1:0] imem_strb,
    input  logic [DATA_W-1:0]   imem_wdata,
    output logic                imem_gnt,
    output logic                imem_err,
    output logic [DATA_W-1:0]   imem_rdata,

    input  logic                dmem_req,
    input  logic                dmem_wen,
    input  logic [ADDR_W-1:0]   dmem_addr,
    input  logic [DATA_W/8-1:0] dmem_strb,
    input  logic [DATA_W-1:0]   dmem_wdata,
    output logic                dmem_gnt,
    output logic                dmem_err,
    output logic [DATA_W-1:0]   dmem_rdata,

    output logic                mem_req,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_strb,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_err,
    input  logic [DATA_W-1:0]   mem_rdata
);

    logic     lock_v;
    arb_sel_t lock_sel;
    logic     rsp_v;
    arb_sel_t rsp_sel;

    logic     lock_v_nxt;
    arb_sel_t lock_sel_nxt;
    logic     rsp_v_nxt;
    arb_sel_t rsp_sel_nxt;

    arb_sel_t sel;
    logic     starve_hit;
    logic     grant;

`ifdef CORE_MEM_ARB_FAIRNESS_EN
    logic [3:0] starve_cnt;
    logic [3:0] starve_cnt_nxt;

    assign starve_hit = imem_req
                     && (starve_cnt >= 4'(STARVE_LIMIT));

    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (!imem_req || (grant && sel == ARB_IMEM))
            starve_cnt_nxt = 4'd0;
        else if (grant && sel == ARB_DMEM
                 && starve_cnt != 4'hf)
            starve_cnt_nxt = starve_cnt + 4'd1;
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn)
            starve_cnt <= 4'd0;
        else
            starve_cnt <= starve_cnt_nxt;
    end
`else
    logic fair_unused;
    assign fair_unused = (STARVE_LIMIT > 0);
    assign starve_hit  = 1'b0;
`endif

    // A locked owner keeps the port until it is granted.
    always_comb begin
        sel = ARB_IMEM;
        if (lock_v)
            sel = lock_sel;
        else if (starve_hit)
            sel = ARB_IMEM;
        else if (dmem_req)
            sel = ARB_DMEM;
    end

    assign grant = mem_req && mem_gnt;

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            lock_v   <= 1'b0;
            lock_sel <= ARB_IMEM;
            rsp_v    <= 1'b0;
            rsp_sel  <= ARB_IMEM;
        end else begin
            lock_v   <= lock_v_nxt;
            lock_sel <= lock_sel_nxt;
            rsp_v    <= rsp_v_nxt;
            rsp_sel  <= rsp_sel_nxt;
        end
    end

    // Dropping req while locked simply releases the lock.
    always_comb begin
        lock_v_nxt   = mem_req && !mem_gnt;
        lock_sel_nxt = sel;
        rsp_v_nxt    = grant;
        rsp_sel_nxt  = sel;
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_wen   = imem_wen;
        mem_addr  = imem_addr;
        mem_strb  = imem_strb;
        mem_wdata = imem_wdata;
        imem_gnt  = 1'b0;
        dmem_gnt  = 1'b0;
        unique case (sel)
            ARB_IMEM: begin
                mem_req  = imem_req;
                imem_gnt = mem_gnt;
            end
            ARB_DMEM: begin
                mem_req   = dmem_req;
                mem_wen   = dmem_wen;
                mem_addr  = dmem_addr;
                mem_strb  = dmem_strb;
                mem_wdata = dmem_wdata;
                dmem_gnt  = mem_gnt;
            end
            default: ;
        endcase
        if (!g_resetn) begin
            mem_req  = 1'b0;
            imem_gnt = 1'b0;
            dmem_gnt = 1'b0;
        end
    end

    assign imem_rdata = mem_rdata;
    assign dmem_rdata = mem_rdata;

    assign imem_err = g_resetn && mem_err && rsp_v
                   && rsp_sel == ARB_IMEM;
    assign dmem_err = g_resetn && mem_err && rsp_v
                   && rsp_sel == ARB_DMEM;

endmodule
